// File: rtl/noc_pkg.sv
// Shared types and constants for the NoC output-port arbiter.
package noc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RELEASE
  } arb_state_t;

  localparam int WIDTH_PKT_DEF = 12;
  localparam int ADDR_W        = 4;   // destination address lives in the packet MSBs
  localparam int MODE_RR       = 0;
  localparam int MODE_FIXED    = 1;

endpackage

// File: rtl/noc_rr_arbiter_if.sv
// Bundle of the input req/ack channels and the single output channel of the arbiter.
interface noc_rr_arbiter_if #(
  parameter int N_IN      = 5,
  parameter int WIDTH_PKT = noc_pkg::WIDTH_PKT_DEF
);
  localparam int SW = $clog2(N_IN);

  logic [N_IN-1:0]           in_req;
  logic [N_IN-1:0]           in_ack;
  logic [N_IN*WIDTH_PKT-1:0] in_data;
  logic                      out_req;
  logic                      out_ack;
  logic [WIDTH_PKT-1:0]      out_data;
  logic [SW-1:0]             out_src;

  // master: the routing stage feeding packets and the sink acknowledging them
  modport master (
    output in_req, in_data, out_ack,
    input  in_ack, out_req, out_data, out_src
  );

  // slave: the arbiter itself
  modport slave (
    input  in_req, in_data, out_ack,
    output in_ack, out_req, out_data, out_src
  );

endinterface

// File: rtl/pkt_fifo.sv
// Synchronous FIFO with combinational head output, wrapping pointers and an occupancy count.
module pkt_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: the storage array has no reset; the count alone decides validity,
  // so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: state is updated with <= so every register samples pre-edge values,
  // independent of the order of statements or processes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/noc_rr_arbiter.sv
// Router output-port arbiter: buffers N_IN four-phase inputs and forwards one packet at a time.
module noc_rr_arbiter
  import noc_pkg::*;
#(
  parameter int N_IN      = 5,
  parameter int WIDTH_PKT = WIDTH_PKT_DEF,
  parameter int DEPTH     = 2,
  parameter int MODE      = MODE_RR
) (
  input logic              clk,
  input logic              rst,
  noc_rr_arbiter_if.slave  bus
);

  localparam int SW = $clog2(N_IN);

  typedef struct packed {
    logic          valid;
    logic [SW-1:0] idx;
  } grant_t;

  logic [N_IN-1:0]      ack, push, pop, full, empty;
  logic [WIDTH_PKT-1:0] head [N_IN];
  arb_state_t           state, state_nxt;
  logic [SW-1:0]        last, src;
  logic [WIDTH_PKT-1:0] data_q;
  grant_t               grant;
  logic                 req_c, pop_en;

  // Input side: capture on the first edge req is seen with space, hold ack until req drops.
  assign push = bus.in_req & ~ack & ~full;

  always_ff @(posedge clk) begin
    if (rst) begin
      ack <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (push[i])                     ack[i] <= 1'b1;
        else if (ack[i] && !bus.in_req[i]) ack[i] <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_fifo
    pkt_fifo #(
      .WIDTH (WIDTH_PKT),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[gi]),
      .pop   (pop[gi]),
      .din   (bus.in_data[gi*WIDTH_PKT +: WIDTH_PKT]),
      .dout  (head[gi]),
      .full  (full[gi]),
      .empty (empty[gi])
    );
    assign pop[gi] = pop_en && (src == SW'(gi));
  end

  // Scan from the highest candidate down so the first-priority index is written last.
  function automatic grant_t pick(input logic [N_IN-1:0] ne, input logic [SW-1:0] lst);
    grant_t        g;
    int            idx;
    logic [SW-1:0] idx_b;
    g = '0;
    for (int k = N_IN; k >= 1; k--) begin
      idx   = (MODE == MODE_FIXED) ? (k - 1) : ((int'(lst) + k) % N_IN);
      idx_b = SW'(idx);
      if (ne[idx_b]) begin
        g.valid = 1'b1;
        g.idx   = idx_b;
      end
    end
    return g;
  endfunction

  assign grant = pick(~empty, last);

  // State register plus the registered grant, packet and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      data_q <= '0;
      src    <= '0;
      last   <= SW'(N_IN - 1);
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant.valid) begin
        data_q <= head[grant.idx];
        src    <= grant.idx;
      end
      if (pop_en) last <= src;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant.valid)  state_nxt = HOLD;
      HOLD:    if (bus.out_ack)  state_nxt = RELEASE;
      RELEASE: if (!bus.out_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_c  = 1'b0;
    pop_en = 1'b0;
    if (state == HOLD) begin
      req_c  = 1'b1;
      pop_en = bus.out_ack;
    end
  end

  assign bus.in_ack   = ack;
  assign bus.out_req  = req_c;
  assign bus.out_data = data_q;
  assign bus.out_src  = src;

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter driven side by side.
module tb_noc_rr_arbiter;

  localparam int N = 5;
  localparam int W = 12;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   feed_en = 0;
  int   sent [N];

  noc_rr_arbiter_if #(.N_IN(N), .WIDTH_PKT(W)) bus_rr ();
  noc_rr_arbiter_if #(.N_IN(N), .WIDTH_PKT(W)) bus_fx ();

  noc_rr_arbiter #(.N_IN(N), .WIDTH_PKT(W), .DEPTH(2), .MODE(0)) dut_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus_rr)
  );

  noc_rr_arbiter #(.N_IN(N), .WIDTH_PKT(W), .DEPTH(2), .MODE(1)) dut_fx (
    .clk (clk),
    .rst (rst),
    .bus (bus_fx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Four-phase senders on inputs 1 and 3 of the fixed-priority instance, 3 packets each.
  task automatic feed_tick();
    for (int i = 1; i <= 3; i += 2) begin
      if (bus_fx.in_req[i] && bus_fx.in_ack[i]) begin
        bus_fx.in_req[i] = 1'b0;
        sent[i]++;
      end else if (!bus_fx.in_req[i] && !bus_fx.in_ack[i] && sent[i] < 3) begin
        bus_fx.in_data[i*W +: W] = W'(12'h200 + i*16 + sent[i]);
        bus_fx.in_req[i] = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (feed_en) feed_tick();
  endtask

  // Zero-latency sink: wait (bounded) for out_req, capture, complete the handshake.
  task automatic sink(input bit fx, output logic [2:0] src, output logic [W-1:0] data);
    int n = 0;
    while (!(fx ? bus_fx.out_req : bus_rr.out_req) && n < 40) begin
      step();
      n++;
    end
    check("sink_req", fx ? bus_fx.out_req : bus_rr.out_req, 1);
    src  = fx ? bus_fx.out_src  : bus_rr.out_src;
    data = fx ? bus_fx.out_data : bus_rr.out_data;
    if (fx) bus_fx.out_ack = 1'b1; else bus_rr.out_ack = 1'b1;
    step();
    check("sink_drop", fx ? bus_fx.out_req : bus_rr.out_req, 0);
    if (fx) bus_fx.out_ack = 1'b0; else bus_rr.out_ack = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]   s;
    logic [W-1:0] d;

    rst = 1'b1;
    bus_rr.in_req = '0; bus_rr.in_data = '0; bus_rr.out_ack = 1'b0;
    bus_fx.in_req = '0; bus_fx.in_data = '0; bus_fx.out_ack = 1'b0;
    for (int i = 0; i < N; i++) sent[i] = 0;
    step();
    step();

    // Reset state
    check("rst_out_req", bus_rr.out_req, 0);
    check("rst_in_ack", bus_rr.in_ack, 0);
    check("rst_out_data", bus_rr.out_data, 0);
    check("rst_out_src", bus_rr.out_src, 0);
    check("rst_fx_out_req", bus_fx.out_req, 0);
    rst = 1'b0;

    // Single packet on input 2
    bus_rr.in_data[2*W +: W] = 12'h1A5;
    bus_rr.in_req[2] = 1'b1;
    step();
    check("single_ack", bus_rr.in_ack, 5'b00100);
    check("single_req_early", bus_rr.out_req, 0);
    bus_rr.in_req[2] = 1'b0;
    step();
    check("single_req", bus_rr.out_req, 1);
    check("single_data", bus_rr.out_data, 12'h1A5);
    check("single_src", bus_rr.out_src, 2);
    check("single_ack_fall", bus_rr.in_ack, 0);
    bus_rr.out_ack = 1'b1;
    step();
    check("single_release", bus_rr.out_req, 0);
    bus_rr.out_ack = 1'b0;
    step();
    step();
    check("single_empty", bus_rr.out_req, 0);

    // Fresh pointer: round-robin over one packet per input
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) bus_rr.in_data[i*W +: W] = W'(12'h100 + i);
    bus_rr.in_req = '1;
    step();
    check("rr_all_ack", bus_rr.in_ack, 5'b11111);
    bus_rr.in_req = '0;
    step();
    for (int i = 0; i < N; i++) begin
      sink(1'b0, s, d);
      check($sformatf("rr_src%0d", i), s, i);
      check($sformatf("rr_data%0d", i), d, 12'h100 + i);
    end

    // Reload inputs 3 and 0 with input 4 last granted
    bus_rr.in_data[0*W +: W] = 12'h120;
    bus_rr.in_data[3*W +: W] = 12'h123;
    bus_rr.in_req = 5'b01001;
    step();
    bus_rr.in_req = '0;
    step();
    sink(1'b0, s, d);
    check("reload_src_a", s, 0);
    check("reload_data_a", d, 12'h120);
    sink(1'b0, s, d);
    check("reload_src_b", s, 3);
    check("reload_data_b", d, 12'h123);

    // Backpressure on input 0 with the sink stalled
    bus_rr.in_data[0 +: W] = 12'hA01;
    bus_rr.in_req[0] = 1'b1;
    step();
    check("bp_ack1", bus_rr.in_ack[0], 1);
    bus_rr.in_req[0] = 1'b0;
    step();
    bus_rr.in_data[0 +: W] = 12'hA02;
    bus_rr.in_req[0] = 1'b1;
    step();
    check("bp_ack2", bus_rr.in_ack[0], 1);
    check("bp_hold_data", bus_rr.out_data, 12'hA01);
    bus_rr.in_req[0] = 1'b0;
    step();
    bus_rr.in_data[0 +: W] = 12'hA03;
    bus_rr.in_req[0] = 1'b1;
    step();
    check("bp_full_a", bus_rr.in_ack[0], 0);
    step();
    check("bp_full_b", bus_rr.in_ack[0], 0);
    bus_rr.out_ack = 1'b1;
    step();
    check("bp_pop_edge", bus_rr.in_ack[0], 0);
    check("bp_pop_req", bus_rr.out_req, 0);
    bus_rr.out_ack = 1'b0;
    step();
    check("bp_ack3", bus_rr.in_ack[0], 1);
    bus_rr.in_req[0] = 1'b0;
    sink(1'b0, s, d);
    check("bp_order2", d, 12'hA02);
    sink(1'b0, s, d);
    check("bp_order3", d, 12'hA03);

    // Fixed priority: inputs 1 and 3 both backlogged
    feed_en = 1'b1;
    feed_tick();
    for (int j = 0; j < 6; j++) begin
      sink(1'b1, s, d);
      check($sformatf("fx_src%0d", j), s, (j < 3) ? 1 : 3);
      check($sformatf("fx_data%0d", j), d, (j < 3) ? (12'h210 + j) : (12'h230 + j - 3));
    end
    feed_en = 1'b0;

    // Reset while holding a packet with a second one buffered
    bus_rr.in_data[1*W +: W] = 12'h3C1;
    bus_rr.in_req[1] = 1'b1;
    step();
    bus_rr.in_req[1] = 1'b0;
    step();
    bus_rr.in_data[1*W +: W] = 12'h3C2;
    bus_rr.in_req[1] = 1'b1;
    step();
    check("mid_pre_req", bus_rr.out_req, 1);
    check("mid_pre_ack", bus_rr.in_ack[1], 1);
    rst = 1'b1;
    step();
    check("mid_out_req", bus_rr.out_req, 0);
    check("mid_out_data", bus_rr.out_data, 0);
    check("mid_out_src", bus_rr.out_src, 0);
    check("mid_in_ack", bus_rr.in_ack, 0);
    step();
    check("mid_ack_in_rst", bus_rr.in_ack, 0);
    rst = 1'b0;
    bus_rr.in_req[1] = 1'b0;
    step();
    step();
    step();
    check("mid_after_req", bus_rr.out_req, 0);
    check("mid_after_ack", bus_rr.in_ack, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_rr_arbiter.md
# noc_rr_arbiter

Clocked, parametrised successor of the two-input router-port arbiter. It collects packets from `N_IN` four-phase req/ack input channels (e.g. up, down, left, right, local) into per-input FIFOs and forwards them one at a time on a single four-phase output channel. Arbitration is round-robin or fixed-priority, selected by parameter. It sits at each router output port, between the input-port routing stage and the link or local sink.

## Interface
- `N_IN`, 5: number of input channels, 2..8.
- `WIDTH_PKT`, 12: packet width, with the address field in the MSBs; carried unmodified.
- `DEPTH`, 2: entries per input FIFO; power of two, ≥1.
- `MODE`, 0: 0 = round-robin; 1 = fixed priority, lowest index wins.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_req` in `N_IN`: per-input request, four-phase.
- `in_ack` out `N_IN`: per-input acknowledge.
- `in_data` in `N_IN*WIDTH_PKT`: input `i` occupies bits `[i*WIDTH_PKT +: WIDTH_PKT]`.
- `out_req` out 1: output request.
- `out_ack` in 1: output acknowledge.
- `out_data` out `WIDTH_PKT`: granted packet.
- `out_src` out `$clog2(N_IN)`: index of the granted input.

## Operation
- Reset values:
  - all `in_ack` = 0, `out_req` = 0, `out_data` = 0, `out_src` = 0;
  - all FIFOs empty;
  - the round-robin pointer `last` = `N_IN-1`, so input 0 has first priority;
  - FSM in `IDLE`.
- Reset asserted mid-transfer:
  - all of the above applies on the next edge;
  - buffered packets are discarded;
  - a sender holding `req` high is re-acknowledged only after reset deasserts.
- Input side, per input `i`:
  - Push when, on an edge, `in_req[i]`=1, `in_ack[i]`=0 and FIFO `i` is not full. That edge writes `in_data[i]` and sets `in_ack[i]`=1.
  - `in_ack[i]` stays 1 until `in_req[i]`=0 is sampled; `in_ack[i]`=0 on that edge.
  - FIFO full: `in_ack[i]` is withheld (backpressure), with no loss and no overwrite.
  - A push and a pop on the same FIFO in the same cycle are both performed; the count is unchanged.
- Grant selection, over the non-empty FIFOs:
  - `MODE`=0: the first non-empty index scanning `last+1, last+2, …` modulo `N_IN`.
  - `MODE`=1: the lowest non-empty index; `last` is ignored.
- Output FSM, type `arb_state_t`:
  - `IDLE`: if any FIFO is non-empty, latch the grant `g`, set `out_data`=head of FIFO `g`, `out_src`=`g`, `out_req`=1, and go to `HOLD`.
  - `HOLD`: `out_data` and `out_src` are stable. When `out_ack`=1 is sampled: `out_req`=0, pop FIFO `g`, `last`=`g`, go to `RELEASE`.
  - `RELEASE`: when `out_ack`=0 is sampled, go to `IDLE`.
- `out_data` and `out_src` keep their last values outside `HOLD`.
- Packets from the same input leave in arrival order.

## Timing
- Input capture: the ack rises on the first edge where `req` is seen high and space exists. Latency is 1 cycle, or it is deferred while the FIFO is full.
- Empty FIFO to `out_req`: a packet pushed at edge t is head at t. `IDLE` samples it at edge t+1, so `out_req`=1 after t+1. Earliest output is 1 cycle after the input ack.
- Output handshake: `out_req` falls on the edge after `out_ack`=1 is sampled. The next `out_req` rises no earlier than the second edge after `out_ack`=0 is sampled (`RELEASE`→`IDLE`→`HOLD`).
- Minimum 3 cycles per output packet with a zero-latency sink.
- Round-robin fairness: with all inputs continuously backlogged, each input is granted exactly once every `N_IN` grants.

## Structure
- Package `noc_pkg` holds:
  - `arb_state_t` (`IDLE`, `HOLD`, `RELEASE`);
  - default `WIDTH_PKT`;
  - `MODE_RR` / `MODE_FIXED` constants;
  - the address-field width constant.
- Sub-module `pkt_fifo`: a synchronous FIFO with parameters `WIDTH`, `DEPTH`.
  - Ports: `clk`, `rst`, `push`, `pop`, `din`, `dout` (head, not registered), `full`, `empty`.
  - Wrapping read/write pointers plus an occupancy count of `$clog2(DEPTH)+1` bits.
  - Instantiated `N_IN` times via generate.
- Top level: per-input ack logic, the grant function, and the FSM.

## Test plan
- Reset, then single packet: drive `in_req[2]`=1 with `in_data[2]`=12'h1A5.
  - Required: `in_ack[2]`=1 after 1 edge, then `out_req`=1, `out_data`=12'h1A5, `out_src`=2.
  - Complete the handshake; `out_req` returns to 0 and the FIFOs are empty.
- Round-robin, `MODE`=0: preload one packet on each of inputs 0–4 (values 0x100+i), sink acks immediately.
  - Required: `out_src` order is 0,1,2,3,4.
  - Then reload inputs 3 and 0 while 4 was last: order is 0,3.
- Fixed priority, `MODE`=1: inputs 1 and 3 each continuously backlogged with 3 packets.
  - Required: all 3 from input 1 are output before any from input 3.
- Backpressure, `DEPTH`=2: hold `out_ack`=0 and push 3 packets on input 0.
  - Required: the first two are acked; the third `in_ack` stays 0 until the first output pop, then is acked.
  - Output order matches input order.
- Reset mid-`HOLD`: assert `rst` while `out_req`=1 with 2 packets buffered.
  - Required: next edge `out_req`=0, `out_data`=0, `out_src`=0, all `in_ack`=0, all FIFOs empty.
  - After deassert with no new input, `out_req` stays 0.
